// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared types and helpers for the SPI audio receiver
//
// Purpose : state encoding and elaboration-time helpers used by spi_audio_rx.
// Contents: spi_rx_state_t  - receiver FSM states
//           sample_on_rise  - 1 when the sample edge is rising SCLK
//           ch_width        - channel index width, max(1, $clog2(n))
package spi_rx_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      ACTIVE    = 2'd2
   } spi_rx_state_t;

   // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling SCLK.
   function automatic bit sample_on_rise(input bit cpol, input bit cpha);
      return (cpol == cpha);
   endfunction

   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-stage synchronizer with edge detection
//
// Purpose : brings an asynchronous input into the clk domain and flags edges.
// Ports   : clk_i    system clock
//           reset_i  synchronous active-high reset (chain loads RESET_LEVEL)
//           din_i    asynchronous input
//           level_o  synchronized level (last sync stage)
//           rise_o   one-cycle pulse on a synchronized 0->1 transition
//           fall_o   one-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
         hist_q <= RESET_LEVEL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_audio_rx.sv
// rtl/spi_audio_rx.sv - parametrised SPI slave receiver for multi-channel audio words
//
// Purpose : oversamples SCLK/MOSI/CS in the clk_25mhz domain, shifts words MSB
//           first, tags each with a channel index and reports frame end status.
// Ports   : clk_25mhz   system clock
//           reset       synchronous active-high reset
//           spi_sclk    SCLK (asynchronous)
//           spi_mosi    MOSI (asynchronous)
//           spi_cs      chip select (asynchronous, polarity CS_ACTIVE_HIGH)
//           rx_data     last completed word, held until the next rx_valid
//           rx_ch       channel index of rx_data
//           rx_valid    one-cycle pulse per completed word
//           frame_done  one-cycle pulse on a clean frame end
//           frame_err   one-cycle pulse on a malformed frame end
module spi_audio_rx
   import spi_rx_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int NUM_CH         = 2,
   parameter bit CPOL           = 1'b0,
   parameter bit CPHA           = 1'b0,
   parameter bit CS_ACTIVE_HIGH = 1'b1,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                        clk_25mhz,
   input  logic                        reset,
   input  logic                        spi_sclk,
   input  logic                        spi_mosi,
   input  logic                        spi_cs,
   output logic [DATA_W-1:0]           rx_data,
   output logic [ch_width(NUM_CH)-1:0] rx_ch,
   output logic                        rx_valid,
   output logic                        frame_done,
   output logic                        frame_err
);

   localparam int CH_W  = ch_width(NUM_CH);
   localparam int BIT_W = $clog2(DATA_W);
   localparam int SET_W = $clog2(SYNC_STAGES + 1);

   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);
   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
   localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SYNC_STAGES);
   localparam bit               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
   localparam bit               CS_IDLE_LVL = ~CS_ACTIVE_HIGH;

   // ------------------------------------------------------------------
   // Synchronizers. MOSI goes through the same depth so its level lines
   // up with the SCLK edge pulse; its own edges are not needed.
   // ------------------------------------------------------------------
   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic cs_lvl, cs_rise_unused, cs_fall_unused;
   logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(CPOL)) u_sync_sclk (
      .clk_i   (clk_25mhz),
      .reset_i (reset),
      .din_i   (spi_sclk),
      .level_o (sclk_lvl_unused),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(CS_IDLE_LVL)) u_sync_cs (
      .clk_i   (clk_25mhz),
      .reset_i (reset),
      .din_i   (spi_cs),
      .level_o (cs_lvl),
      .rise_o  (cs_rise_unused),
      .fall_o  (cs_fall_unused)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
      .clk_i   (clk_25mhz),
      .reset_i (reset),
      .din_i   (spi_mosi),
      .level_o (mosi_lvl),
      .rise_o  (mosi_rise_unused),
      .fall_o  (mosi_fall_unused)
   );

   logic sample;
   logic cs_act;

   assign sample = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign cs_act = CS_ACTIVE_HIGH ? cs_lvl : ~cs_lvl;

   // ------------------------------------------------------------------
   // State. The shift register holds only the DATA_W-1 earlier bits; the
   // final bit comes straight from MOSI on the completing edge.
   // settle_q keeps WAIT_IDLE from trusting the reset-loaded (inactive) CS
   // value: it only exits once the chain has refilled from the real pin,
   // so a reset released mid-frame cannot start capture half-way in.
   // ------------------------------------------------------------------
   spi_rx_state_t     state_q, state_d;
   logic [DATA_W-2:0] sr_q, sr_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
   logic [1:0]        word_cnt_q, word_cnt_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [CH_W-1:0]   rx_ch_q, rx_ch_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic [DATA_W-1:0] word;

   assign word = {sr_q, mosi_lvl};

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state_q      <= WAIT_IDLE;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         ch_idx_q     <= '0;
         word_cnt_q   <= '0;
         settle_q     <= '0;
         rx_data_q    <= '0;
         rx_ch_q      <= '0;
         rx_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         ch_idx_q     <= ch_idx_d;
         word_cnt_q   <= word_cnt_d;
         settle_q     <= settle_d;
         rx_data_q    <= rx_data_d;
         rx_ch_q      <= rx_ch_d;
         rx_valid_q   <= rx_valid_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      ch_idx_d     = ch_idx_q;
      word_cnt_d   = word_cnt_q;
      settle_d     = settle_q;
      rx_data_d    = rx_data_q;
      rx_ch_d      = rx_ch_q;
      rx_valid_d   = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;

      if (settle_q != SETTLE_MAX) begin
         settle_d = settle_q + 1'b1;
      end

      case (state_q)
         WAIT_IDLE: begin
            if ((settle_q == SETTLE_MAX) && !cs_act) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            if (cs_act) begin
               state_d    = ACTIVE;
               bit_cnt_d  = '0;
               ch_idx_d   = '0;
               word_cnt_d = '0;
            end
         end

         ACTIVE: begin
            if (sample) begin
               sr_d = word[DATA_W-2:0];
               if (bit_cnt_q == LAST_BIT) begin
                  rx_data_d  = word;
                  rx_ch_d    = ch_idx_q;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  if (word_cnt_q != 2'b11) begin
                     word_cnt_d = word_cnt_q + 1'b1;
                  end
                  ch_idx_d = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            // Frame end is judged on the counters after any word that
            // completed in this same cycle.
            if (!cs_act) begin
               state_d = IDLE;
               if (bit_cnt_d != '0) begin
                  frame_err_d = 1'b1;
               end else if (word_cnt_d != '0) begin
                  if (ch_idx_d == '0) begin
                     frame_done_d = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end
            end
         end

         default: state_d = WAIT_IDLE;
      endcase
   end

   assign rx_data    = rx_data_q;
   assign rx_ch      = rx_ch_q;
   assign rx_valid   = rx_valid_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule

// File: doc/spi_audio_rx.md
# spi_audio_rx

Parametrised SPI slave receiver that captures audio words from the Pico, replacing the fixed 16-bit single-word receiver in `pedal_top`. All SPI inputs are oversampled in the `clk_25mhz` domain. Each CS frame carries one or more words, and every received word is tagged with a channel index. The block reports frame completion and framing errors, and feeds the bypass mux and effect chain through a one-cycle valid pulse.

## Interface
- `DATA_W`, 16: bits per word, ≥ 2, MSB first.
- `NUM_CH`, 2: words per complete frame (channels), ≥ 1.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 samples on the leading edge, 1 samples on the trailing edge.
- `CS_ACTIVE_HIGH`, 1: CS polarity.
- `SYNC_STAGES`, 2: synchronizer depth, ≥ 2.
- `clk_25mhz`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `spi_sclk`  in  1  SCLK from the Pico (asynchronous).
- `spi_mosi`  in  1  MOSI from the Pico (asynchronous).
- `spi_cs`  in  1  chip select from the Pico (asynchronous).
- `rx_data`  out  DATA_W  last completed word.
- `rx_ch`  out  CH_W  channel index of `rx_data`. CH_W = max(1, $clog2(NUM_CH)).
- `rx_valid`  out  1  one-cycle pulse when a word completes.
- `frame_done`  out  1  one-cycle pulse on a clean frame end.
- `frame_err`  out  1  one-cycle pulse on a malformed frame end.

## Operation
- Synchronization:
  - `spi_sclk`, `spi_mosi` and `spi_cs` each pass through SYNC_STAGES flip-flops.
  - Edges are detected from the last sync stage against one extra history register.
- Sample edge selection:
  - Rising SCLK when CPOL == CPHA.
  - Falling SCLK otherwise.
  - The other edge is ignored.
- States:
  - WAIT_IDLE (entered on reset): go to IDLE once synchronized CS is inactive. This blocks capture if reset releases in mid-frame.
  - IDLE: synchronized CS goes active → ACTIVE, with `bit_cnt`=0, `ch_idx`=0 and `word_cnt`=0.
  - ACTIVE, on each sample edge: shift register ← {sr[DATA_W-2:0], mosi_sync}; `bit_cnt`++.
  - ACTIVE, when the sample edge completes bit DATA_W-1:
    - `rx_data` ← full word, `rx_ch` ← `ch_idx`, `rx_valid` = 1.
    - `bit_cnt` ← 0, `word_cnt`++.
    - `ch_idx` increments and wraps from NUM_CH-1 to 0.
  - ACTIVE, CS goes inactive → IDLE, then evaluate the frame:
    - `bit_cnt` ≠ 0: `frame_err`; the partial word is discarded.
    - `bit_cnt` = 0, `ch_idx` = 0, `word_cnt` ≥ 1: `frame_done`.
    - `bit_cnt` = 0, `ch_idx` ≠ 0: `frame_err`.
    - `word_cnt` = 0 with no bits received: no pulse.
- Simultaneous events:
  - A completing sample edge and CS deassert in the same cycle: the word is accepted first (`rx_valid`), then the frame is evaluated on the updated counters. Both pulses appear in that cycle.
  - SCLK edges while in IDLE or WAIT_IDLE are ignored.
- `rx_data` and `rx_ch` hold their values until the next `rx_valid`.
- `frame_done` and `frame_err` are mutually exclusive.
- `word_cnt` saturates at its maximum and is only used for the ≥ 1 test.

## Timing
- Reset values:
  - All outputs 0.
  - State WAIT_IDLE.
  - Sync chains loaded with their inactive levels: SCLK = CPOL, CS inactive, MOSI 0.
  - Counters 0.
- Latency: `rx_valid` rises SYNC_STAGES+1 `clk_25mhz` edges after the first clock edge that samples the raw SCLK sample edge. That is 3 cycles at default, with ±1 cycle of asynchronous uncertainty.
- Frame-end latency: `frame_done`/`frame_err` rise SYNC_STAGES+1 cycles after raw CS deasserts.
- SCLK constraints:
  - SCLK high and low must each last ≥ SYNC_STAGES+1 clock periods (120 ns at default), so SCLK ≤ 4 MHz. The Pico runs 2 MHz.
  - MOSI must be stable from ≥ 1 clock period before the raw sample edge.
- CS inter-frame gap: ≥ SYNC_STAGES+1 cycles inactive.
- All outputs are registered.

## Structure
- Package `spi_rx_pkg` holds:
  - State enum `spi_rx_state_t` with values WAIT_IDLE, IDLE, ACTIVE.
  - Function `sample_on_rise(cpol, cpha)`.
  - Function `ch_width(n)`, returning max(1, $clog2(n)).
- Sub-module `sync_edge_detect`:
  - Parameters: SYNC_STAGES, reset level.
  - Outputs: synchronized level, rise pulse, fall pulse.
  - Instanced for SCLK and CS.
  - MOSI uses the same module so that it stays aligned with SCLK.

## Test plan
- Mode 0, defaults. One CS frame carrying 16'hC0DE then 16'h1234 → `rx_valid` ×2 with (C0DE, ch 0) then (1234, ch 1). Then one `frame_done`, no `frame_err`.
- Partial word: 9 bits then CS inactive → no `rx_valid`, one `frame_err`. The next frame with 16'hA5A5, 16'h5A5A is received with ch 0 and ch 1.
- Short frame: a single word 16'hBEEF → `rx_valid` (BEEF, ch 0), then `frame_err` at CS release and no `frame_done`.
- Wrap: 4 words 0x0001..0x0004 in one frame → `rx_ch` sequence 0, 1, 0, 1, then one `frame_done`.
- CPOL=1, CPHA=1, DATA_W=24, NUM_CH=1: 24'h800001 → `rx_data`=800001, `rx_ch`=0, then `frame_done`.
- Reset mid-frame: `reset` asserted after 8 bits with CS held active → all outputs 0. The remaining bits produce nothing, and no pulse fires at that CS release. The next frame carrying 16'hC0DE, 16'h0000 is received correctly.
